// File: rtl/psram_arbiter_n_pkg.sv
// Shared types and the channel-pick helper for the PSRAM arbiter.
package psram_arb_pkg;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_COMPLETE
  } arb_state_e;

  localparam int unsigned MAX_CH = 8;
  localparam int unsigned IDX_W  = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First full slot at or after ptr, wrapping n-1 -> 0; ptr = 0 gives lowest-index-first.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] full_vec,
                                    input logic [IDX_W-1:0]  ptr,
                                    input int unsigned       n);
    pick_t          res;
    logic [IDX_W:0] sum;
    res = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(n)) sum = sum - (IDX_W+1)'(n);
      if (i < n && !res.found && full_vec[sum[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = sum[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/psram_arbiter_n_if.sv
// Requester-side and controller-side signals of the PSRAM arbiter.
interface psram_arbiter_n_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 8
);
  logic [NUM_CH-1:0]        i_req_wr;
  logic [NUM_CH-1:0]        i_req_rd;
  logic [NUM_CH*ADDR_W-1:0] i_req_addr;
  logic [NUM_CH*DATA_W-1:0] i_req_wdata;
  logic [NUM_CH-1:0]        o_slot_full;
  logic [NUM_CH-1:0]        o_done;
  logic [DATA_W-1:0]        o_rdata;
  logic [NUM_CH-1:0]        o_overflow;
  logic                     o_fault;
  logic [ADDR_W-1:0]        o_ps_addr;
  logic                     o_ps_write8;
  logic                     o_ps_read8;
  logic [DATA_W-1:0]        o_ps_wdata;
  logic [DATA_W-1:0]        i_ps_rdata;
  logic                     i_ps_busy;

  // Arbiter view.
  modport master (
    input  i_req_wr, i_req_rd, i_req_addr, i_req_wdata, i_ps_rdata, i_ps_busy,
    output o_slot_full, o_done, o_rdata, o_overflow, o_fault,
           o_ps_addr, o_ps_write8, o_ps_read8, o_ps_wdata
  );

  // Requesters + controller view.
  modport slave (
    output i_req_wr, i_req_rd, i_req_addr, i_req_wdata, i_ps_rdata, i_ps_busy,
    input  o_slot_full, o_done, o_rdata, o_overflow, o_fault,
           o_ps_addr, o_ps_write8, o_ps_read8, o_ps_wdata
  );
endinterface

// File: rtl/psram_arbiter_n_slot.sv
// One-entry command latch for a single requester channel, with sticky overflow.
module psram_arb_slot
  import psram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_stb,
  input  logic              rd_stb,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              clear,
  output logic              full,
  output op_e               op,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              overflow
);

  logic stb;
  assign stb = wr_stb | rd_stb;

  // Capture on an empty slot; any strobe on a full slot (including its done cycle) is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      op       <= OP_RD;
      addr     <= '0;
      wdata    <= '0;
      overflow <= 1'b0;
    end else if (full) begin
      if (stb)   overflow <= 1'b1;
      if (clear) full     <= 1'b0;
    end else if (stb) begin
      full  <= 1'b1;
      op    <= wr_stb ? OP_WR : OP_RD;
      addr  <= addr_in;
      wdata <= wdata_in;
      if (wr_stb && rd_stb) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/psram_arbiter_n.sv
// N-channel arbiter in front of the single 8-bit PSRAM controller port.
module psram_arbiter_n
  import psram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned RR_MODE      = 1,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input logic               i_CLK,
  input logic               i_RST,
  psram_arbiter_n_if.master bus
);

  localparam int unsigned      TMO_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  // Slot arrays are padded to MAX_CH so the 3-bit grant can index them directly.
  logic [MAX_CH-1:0] full_pad;
  op_e               slot_op    [MAX_CH];
  logic [ADDR_W-1:0] slot_addr  [MAX_CH];
  logic [DATA_W-1:0] slot_wdata [MAX_CH];
  logic [NUM_CH-1:0] ovf;

  arb_state_e        state;
  pick_t             pick;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_next;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [NUM_CH-1:0] done_q;
  logic [ADDR_W-1:0] ps_addr;
  logic [DATA_W-1:0] ps_wdata;
  logic              ps_write8;
  logic              ps_read8;
  logic [DATA_W-1:0] rdata;
  logic              fault;

  for (genvar k = 0; k < MAX_CH; k++) begin : g_slot
    if (k < NUM_CH) begin : g_used
      psram_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
        .clk      (i_CLK),
        .rst      (i_RST),
        .wr_stb   (bus.i_req_wr[k]),
        .rd_stb   (bus.i_req_rd[k]),
        .addr_in  (bus.i_req_addr[k*ADDR_W +: ADDR_W]),
        .wdata_in (bus.i_req_wdata[k*DATA_W +: DATA_W]),
        .clear    (done_q[k]),
        .full     (full_pad[k]),
        .op       (slot_op[k]),
        .addr     (slot_addr[k]),
        .wdata    (slot_wdata[k]),
        .overflow (ovf[k])
      );
    end else begin : g_pad
      assign full_pad[k]   = 1'b0;
      assign slot_op[k]    = OP_RD;
      assign slot_addr[k]  = '0;
      assign slot_wdata[k] = '0;
    end
  end

  // Winner selection; fixed priority is round-robin with the pointer pinned to 0.
  always_comb begin
    pick    = rr_pick(full_pad, (RR_MODE != 0) ? rr_ptr : '0, NUM_CH);
    rr_next = (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
  end

  // Command sequencer: one controller transaction at a time, all outputs registered.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= S_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
      done_q    <= '0;
      ps_addr   <= '0;
      ps_wdata  <= '0;
      ps_write8 <= 1'b0;
      ps_read8  <= 1'b0;
      rdata     <= '0;
      fault     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick.found && !bus.i_ps_busy) begin
            grant     <= pick.idx;
            ps_addr   <= slot_addr[pick.idx];
            ps_wdata  <= slot_wdata[pick.idx];
            ps_write8 <= (slot_op[pick.idx] == OP_WR);
            ps_read8  <= (slot_op[pick.idx] == OP_RD);
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ps_write8 <= 1'b0;
          ps_read8  <= 1'b0;
          tmo_cnt   <= '0;
          state     <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.i_ps_busy) begin
            state <= S_WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            fault  <= 1'b1;
            done_q <= NUM_CH'(1) << grant;
            state  <= S_COMPLETE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.i_ps_busy) begin
            if (slot_op[grant] == OP_RD) rdata <= bus.i_ps_rdata;
            done_q <= NUM_CH'(1) << grant;
            state  <= S_COMPLETE;
          end
        end
        S_COMPLETE: begin
          done_q <= '0;
          if (RR_MODE != 0) rr_ptr <= rr_next;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_slot_full = full_pad[NUM_CH-1:0];
  assign bus.o_done      = done_q;
  assign bus.o_rdata     = rdata;
  assign bus.o_overflow  = ovf;
  assign bus.o_fault     = fault;
  assign bus.o_ps_addr   = ps_addr;
  assign bus.o_ps_wdata  = ps_wdata;
  assign bus.o_ps_write8 = ps_write8;
  assign bus.o_ps_read8  = ps_read8;

endmodule

// File: tb/tb_psram_arbiter_n.sv
// Directed scoreboard bench: round-robin 4-channel DUT plus fixed-priority 2-channel DUT.
module tb_psram_arbiter_n;
  import psram_arb_pkg::*;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 8;
  localparam int unsigned NA = 4;
  localparam int unsigned NB = 2;

  typedef struct {
    int unsigned   ch;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  exp_t issue_q[$];
  exp_t done_q[$];

  int unsigned   hold_a, hold_cnt_a, hold_cnt_b;
  logic          nobusy_a;
  logic [DW-1:0] model_rdata;

  psram_arbiter_n_if #(.NUM_CH(NA), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
  psram_arbiter_n_if #(.NUM_CH(NB), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

  psram_arbiter_n #(.NUM_CH(NA), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .BUSY_TIMEOUT(15)) dut_a (
    .i_CLK (clk), .i_RST (rst_a), .bus (bus_a.master));
  psram_arbiter_n #(.NUM_CH(NB), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .BUSY_TIMEOUT(15)) dut_b (
    .i_CLK (clk), .i_RST (rst_b), .bus (bus_b.master));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Controller model A: busy rises the cycle after a strobe and stays high hold_a cycles.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      bus_a.i_ps_busy  <= 1'b0;
      bus_a.i_ps_rdata <= '0;
      hold_cnt_a       <= 0;
    end else if ((bus_a.o_ps_read8 || bus_a.o_ps_write8) && !nobusy_a) begin
      bus_a.i_ps_busy  <= 1'b1;
      bus_a.i_ps_rdata <= model_rdata;
      hold_cnt_a       <= hold_a - 1;
    end else if (bus_a.i_ps_busy) begin
      if (hold_cnt_a == 0) bus_a.i_ps_busy <= 1'b0;
      else hold_cnt_a <= hold_cnt_a - 1;
    end
  end

  // Controller model B: fixed 3-cycle busy.
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      bus_b.i_ps_busy  <= 1'b0;
      bus_b.i_ps_rdata <= '0;
      hold_cnt_b       <= 0;
    end else if (bus_b.o_ps_read8 || bus_b.o_ps_write8) begin
      bus_b.i_ps_busy <= 1'b1;
      hold_cnt_b      <= 2;
    end else if (bus_b.i_ps_busy) begin
      if (hold_cnt_b == 0) bus_b.i_ps_busy <= 1'b0;
      else hold_cnt_b <= hold_cnt_b - 1;
    end
  end

  // Scoreboard monitor for DUT A: every issue and every completion must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a) begin
      if (bus_a.o_ps_read8 || bus_a.o_ps_write8) begin
        check("issue_expected", 64'(issue_q.size() != 0), 64'd1);
        if (issue_q.size() != 0) begin
          e = issue_q.pop_front();
          check("issue_kind", 64'({bus_a.o_ps_write8, bus_a.o_ps_read8}), e.wr ? 64'd2 : 64'd1);
          check("issue_addr", 64'(bus_a.o_ps_addr), 64'(e.addr));
          if (e.wr) check("issue_wdata", 64'(bus_a.o_ps_wdata), 64'(e.wdata));
          done_q.push_back(e);
        end
      end
      if (bus_a.o_done != '0) begin
        check("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          check("done_onehot", 64'(bus_a.o_done), 64'(4'b0001 << e.ch));
          check("done_addr_held", 64'(bus_a.o_ps_addr), 64'(e.addr));
          if (!e.wr) check("done_rdata", 64'(bus_a.o_rdata), 64'(e.rdata));
        end
      end
    end
  end

  function automatic logic [63:0] a_outs();
    return 64'({bus_a.o_slot_full, bus_a.o_done, bus_a.o_rdata, bus_a.o_overflow, bus_a.o_fault,
                bus_a.o_ps_addr, bus_a.o_ps_write8, bus_a.o_ps_read8, bus_a.o_ps_wdata});
  endfunction

  task automatic load_a(input int unsigned k, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus_a.i_req_addr[k*AW +: AW]  = addr;
    bus_a.i_req_wdata[k*DW +: DW] = wd;
  endtask

  task automatic push(input int unsigned ch, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    exp_t e;
    e.ch = ch; e.wr = wr; e.addr = addr; e.wdata = wd; e.rdata = rd;
    issue_q.push_back(e);
  endtask

  task automatic pulse_a(input logic [NA-1:0] wr, input logic [NA-1:0] rd);
    @(posedge clk); #1;
    bus_a.i_req_wr = wr;
    bus_a.i_req_rd = rd;
    @(posedge clk); #1;
    bus_a.i_req_wr = '0;
    bus_a.i_req_rd = '0;
  endtask

  task automatic drain_a(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (issue_q.size() == 0 && done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_a();
    @(posedge clk); #1;
    rst_a = 1'b1;
    issue_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
  endtask

  initial begin
    logic          seen;
    int unsigned   cnt, n_ch1;
    logic          ch0_sent, first_after, ch0_done;
    rst_a = 1'b1; rst_b = 1'b1;
    nobusy_a = 1'b0; hold_a = 4; model_rdata = '0;
    bus_a.i_req_wr = '0; bus_a.i_req_rd = '0; bus_a.i_req_addr = '0; bus_a.i_req_wdata = '0;
    bus_b.i_req_wr = '0; bus_b.i_req_rd = '0; bus_b.i_req_addr = '0; bus_b.i_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_outs_a", a_outs(), 64'd0);
    check("reset_outs_b", 64'({bus_b.o_slot_full, bus_b.o_done, bus_b.o_fault, bus_b.o_ps_write8,
                               bus_b.o_ps_read8, bus_b.o_overflow}), 64'd0);

    // Single read on ch0
    hold_a = 4; model_rdata = 8'hA5;
    load_a(0, 22'h012345, 8'h00);
    push(0, 1'b0, 22'h012345, 8'h00, 8'hA5);
    pulse_a(4'b0000, 4'b0001);
    @(negedge clk);
    check("slot_full_after_capture", 64'(bus_a.o_slot_full), 64'b0001);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.o_done[0]) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("single_read_done_seen", 64'(seen), 64'd1);
    check("slot_full_during_done", 64'(bus_a.o_slot_full[0]), 64'd1);
    @(negedge clk);
    check("slot_free_after_done", 64'(bus_a.o_slot_full[0]), 64'd0);
    check("done_one_cycle", 64'(bus_a.o_done), 64'd0);
    drain_a("single_read_drain");

    // Round-robin: all four at once, then 0+3, then 2 alone, then 0+3 again with pointer at 3
    reset_a();
    hold_a = 2;
    for (int unsigned k = 0; k < NA; k++) begin
      load_a(k, 22'(32'h100 + k), 8'(8'h10 + k));
      push(k, 1'b1, 22'(32'h100 + k), 8'(8'h10 + k), 8'h00);
    end
    pulse_a(4'b1111, 4'b0000);
    drain_a("rr_all_four");
    push(0, 1'b1, 22'h100, 8'h10, 8'h00);
    push(3, 1'b1, 22'h103, 8'h13, 8'h00);
    pulse_a(4'b1001, 4'b0000);
    drain_a("rr_0_3");
    push(2, 1'b1, 22'h102, 8'h12, 8'h00);
    pulse_a(4'b0100, 4'b0000);
    drain_a("rr_2_alone");
    push(3, 1'b1, 22'h103, 8'h13, 8'h00);
    push(0, 1'b1, 22'h100, 8'h10, 8'h00);
    pulse_a(4'b1001, 4'b0000);
    drain_a("rr_wrap_3_0");

    // Overflow: ch1 strobed twice more while full, only the first command issues
    hold_a = 6;
    load_a(1, 22'h200, 8'h55);
    push(1, 1'b1, 22'h200, 8'h55, 8'h00);
    pulse_a(4'b0010, 4'b0000);
    load_a(1, 22'h201, 8'h66);
    pulse_a(4'b0010, 4'b0000);
    pulse_a(4'b0000, 4'b0010);
    @(negedge clk);
    check("overflow_ch1", 64'(bus_a.o_overflow), 64'b0010);
    drain_a("overflow_drain");
    check("overflow_sticky", 64'(bus_a.o_overflow), 64'b0010);
    load_a(2, 22'h250, 8'h99);
    push(2, 1'b1, 22'h250, 8'h99, 8'h00);
    pulse_a(4'b0100, 4'b0100);
    drain_a("wr_rd_together_drain");
    check("overflow_wr_rd", 64'(bus_a.o_overflow), 64'b0110);

    // Timeout on ch3 write, then ch0 read served normally (pointer is at 3)
    nobusy_a = 1'b1; hold_a = 3; model_rdata = 8'h3C;
    load_a(3, 22'h300, 8'h44);
    load_a(0, 22'h301, 8'h00);
    push(3, 1'b1, 22'h300, 8'h44, 8'h00);
    push(0, 1'b0, 22'h301, 8'h00, 8'h3C);
    pulse_a(4'b1000, 4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.o_ps_write8) begin seen = 1'b1; break; end
    end
    check("timeout_issue_seen", 64'(seen), 64'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 15) check("fault_not_early", 64'(bus_a.o_fault), 64'd0);
      if (bus_a.o_done != '0) break;
    end
    check("timeout_latency", 64'(cnt), 64'd16);
    check("fault_set", 64'(bus_a.o_fault), 64'd1);
    nobusy_a = 1'b0;
    drain_a("after_timeout_drain");
    check("fault_sticky", 64'(bus_a.o_fault), 64'd1);

    // Reset during WAIT_DONE aborts; a fresh request afterwards completes
    hold_a = 8;
    load_a(2, 22'h3FFFFF, 8'h00);
    push(2, 1'b0, 22'h3FFFFF, 8'h00, 8'h00);
    pulse_a(4'b0000, 4'b0100);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.o_ps_read8) begin seen = 1'b1; break; end
    end
    check("abort_issue_seen", 64'(seen), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;
    issue_q.delete();
    done_q.delete();
    @(negedge clk);
    check("midreset_outs", a_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_slots_empty", 64'(bus_a.o_slot_full), 64'd0);
    hold_a = 2;
    load_a(1, 22'h123, 8'h77);
    push(1, 1'b1, 22'h123, 8'h77, 8'h00);
    pulse_a(4'b0010, 4'b0000);
    drain_a("post_reset_drain");

    // Fixed priority: ch1 refilled continuously, ch0 strobed mid-transfer must win next IDLE
    bus_b.i_req_addr = {22'h001111, 22'h000AAA};
    bus_b.i_req_wdata = {8'hB1, 8'hB0};
    ch0_sent = 1'b0; first_after = 1'b0; ch0_done = 1'b0; n_ch1 = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      bus_b.i_req_wr = '0;
      if (!bus_b.o_slot_full[1]) bus_b.i_req_wr[1] = 1'b1;
      if (cyc >= 20 && !ch0_sent && bus_b.i_ps_busy) begin
        bus_b.i_req_wr[0] = 1'b1;
        ch0_sent = 1'b1;
      end
      @(negedge clk);
      if (bus_b.o_ps_write8) begin
        if (ch0_sent && !first_after) begin
          first_after = 1'b1;
          check("fp_next_is_ch0", 64'(bus_b.o_ps_addr), 64'h000AAA);
        end else if (!ch0_sent) begin
          n_ch1++;
        end
      end
      if (bus_b.o_done[0]) begin
        ch0_done = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 bus_b.i_req_wr = '0;
    check("fp_ch0_done", 64'(ch0_done), 64'd1);
    check("fp_ch1_served_before", 64'(n_ch1 >= 2), 64'd1);
    check("fp_no_overflow", 64'(bus_b.o_overflow), 64'd0);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_arbiter_n.md
Name: psram_arbiter_n

Overview:
- N-channel arbiter between independent requesters and the single 8-bit PSRAM controller port (address / write8 / read8 / write_data / read_data / busy).
- Each channel posts one pulse-strobed command into its own one-entry slot.
- Arbiter issues one command at a time to the controller, fixed-priority or round-robin, and returns a per-channel completion pulse with read data.
- Sits between the Z80-bus / SD / sound-data masters and the PSRAM controller.

Parameters:
NUM_CH, 2, number of requester channels (2..8)
ADDR_W, 22, PSRAM byte address width
DATA_W, 8, data width
RR_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin
BUSY_TIMEOUT, 15, cycles to wait for busy to rise after a strobe before declaring a fault

Ports:
i_CLK  in  1  system clock
i_RST  in  1  asynchronous, active-high reset
i_req_wr  in  NUM_CH  per-channel write strobe, 1-cycle pulse
i_req_rd  in  NUM_CH  per-channel read strobe, 1-cycle pulse
i_req_addr  in  NUM_CH*ADDR_W  per-channel address, channel k at bits [k*ADDR_W +: ADDR_W]
i_req_wdata  in  NUM_CH*DATA_W  per-channel write data
o_slot_full  out  NUM_CH  slot k holds an unfinished command
o_done  out  NUM_CH  1-cycle completion pulse
o_rdata  out  DATA_W  read data, valid while any o_done bit is high
o_overflow  out  NUM_CH  sticky: strobe arrived while the slot was full
o_fault  out  1  sticky: busy never rose within BUSY_TIMEOUT
o_ps_addr  out  ADDR_W  to controller
o_ps_write8  out  1  to controller, 1-cycle pulse
o_ps_read8  out  1  to controller, 1-cycle pulse
o_ps_wdata  out  DATA_W  to controller
i_ps_rdata  in  DATA_W  from controller
i_ps_busy  in  1  from controller

Behaviour:
- Reset: all outputs 0; all slots empty; RR pointer = 0; FSM = IDLE.
- Reset mid-operation aborts the transfer. No o_done is issued for the aborted command.
- Slot capture:
  - Strobe on an empty slot captures addr, wdata and op at the clock edge. o_slot_full rises the next cycle.
  - Strobe while the slot is full is dropped and sets o_overflow[k]. The slot is unchanged.
  - Write and read strobed together: captured as a write, and o_overflow[k] is set.
  - A strobe in the same cycle the slot's o_done pulses is an overflow. The slot frees one cycle after o_done.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE.
  - IDLE: if any slot is full and i_ps_busy = 0, choose winner g and go to ISSUE.
    - RR_MODE = 1: first full slot at or after the pointer, wrapping at NUM_CH-1 -> 0.
    - RR_MODE = 0: lowest-index full slot.
  - ISSUE, one cycle: drive o_ps_addr / o_ps_wdata from slot g and pulse o_ps_write8 or o_ps_read8 -> WAIT_BUSY.
  - WAIT_BUSY: when i_ps_busy = 1 -> WAIT_DONE. If BUSY_TIMEOUT cycles elapse, set o_fault, treat the command as complete and go to COMPLETE.
  - WAIT_DONE: when i_ps_busy = 0 -> COMPLETE; capture i_ps_rdata on that edge for reads.
  - COMPLETE, one cycle: pulse o_done[g] with o_rdata = captured data (writes: last captured value, don't-care); clear slot g; if RR_MODE = 1, pointer = (g+1) mod NUM_CH. -> IDLE.
- o_ps_addr / o_ps_wdata hold their values from ISSUE through COMPLETE, then hold the last value. The strobes are 0 outside ISSUE.
- Minimum latency, strobe to o_done: 1 (capture) + 1 (IDLE) + 1 (ISSUE) + 1 (WAIT_BUSY) + controller busy time + 1 (COMPLETE).
- Back-to-back transfers: at least one IDLE cycle between commands.

Decomposition:
- Package psram_arb_pkg:
  - typedef op_e {OP_RD, OP_WR}
  - typedef arb_state_e for the five states
  - function rr_pick(full_vec, ptr, n) returning winner index and found flag
- Sub-module psram_arb_slot: one-entry command latch with overflow flag, instantiated NUM_CH times in a generate loop.
- Top holds the FSM, the RR pointer and the timeout counter.

Test Plan:
- Single read: ch0 read addr 0x012345; controller model raises busy 1 cycle after read8, holds it 4 cycles, rdata = 0xA5 -> exactly one o_ps_read8 pulse with o_ps_addr = 0x012345; o_done[0] with o_rdata = 0xA5; o_slot_full[0] low one cycle after o_done.
- Round-robin, NUM_CH = 4: all four channels strobe writes in the same cycle with wdata 0x10..0x13 -> issue order 0,1,2,3. Then channels 0 and 3 strobe together -> order 0,3.
- Fixed priority, RR_MODE = 0: ch1 kept continuously refilled, ch0 strobes once -> ch0 is served at the next IDLE.
- Overflow: ch1 strobes twice while full -> o_overflow[1] = 1 and stays set; only the first command is issued.
- Timeout: controller never raises busy -> o_fault = 1 after 15 WAIT_BUSY cycles; o_done still pulses and the arbiter serves the next slot.
- Reset mid-transfer: assert i_RST during WAIT_DONE -> all outputs 0, slots empty, no o_done. A new request after reset completes normally.
